// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller and its register file.
package alu_pkg;

  localparam int unsigned NRegs = 8;
  localparam int unsigned DataW = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StRead  = 3'd2,
    StExec  = 3'd3,
    StWb    = 3'd4
  } state_e;

  localparam logic [4:0] OpNop   = 5'd0;
  localparam logic [4:0] OpAdd   = 5'd1;
  localparam logic [4:0] OpSub   = 5'd2;
  localparam logic [4:0] OpLleft = 5'd15;
  localparam logic [4:0] OpUadd  = 5'd17;
  localparam logic [4:0] OpUsub  = 5'd18;

  localparam int unsigned ImmBit = 6;

  // Operand byte layout: [7:5] src1, [4:2] src2, [1:0] dest
  localparam int unsigned Wr1Lsb = 5;
  localparam int unsigned Wr2Lsb = 2;
  localparam int unsigned DrLsb  = 0;

endpackage

// File: rtl/regfile_8x8.sv
// 8x8 register file: two operand read ports, one debug read port and one write
// port shared between configuration preload and ALU writeback.
module regfile_8x8
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [DataW-1:0] cfg_data,
  input  logic             wb_we,
  input  logic [2:0]       wb_addr,
  input  logic [DataW-1:0] wb_data,
  input  logic [2:0]       raddr1,
  input  logic [2:0]       raddr2,
  input  logic [2:0]       dbg_sel,
  output logic [DataW-1:0] rdata1,
  output logic [DataW-1:0] rdata2,
  output logic [DataW-1:0] dbg_data
);

  logic [DataW-1:0] regs_q [NRegs];
  logic             we;
  logic [2:0]       waddr;
  logic [DataW-1:0] wdata;

  // Preload and writeback are never active together (IDLE vs WB).
  always_comb begin
    we    = wb_we | cfg_we;
    waddr = wb_we ? wb_addr : cfg_addr;
    wdata = wb_we ? wb_data : cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRegs; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the combinational ALU selector.
// Optional macro ALU_ISSUE_IMMEDIATE_EN: alu_instruct[6] selects the operand byte as data2.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instruct,
  input  logic [7:0] address,
  output logic [7:0] alu_instruct,
  output logic [7:0] alu_address,
  input  logic [2:0] alu_wr1,
  input  logic [2:0] alu_wr2,
  input  logic [1:0] alu_dr,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  input  logic [7:0] alu_ans,
  output logic       done,
  output logic       zero_flag,
  output logic       neg_flag,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data
);

  localparam logic [3:0] WaitInit = 4'(ALU_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  logic [7:0] instr_q, addr_q, data1_q, data2_q;
  logic       done_q, zero_q, neg_q;
  logic       accept, cfg_wr, wb_we, load_ops;
  logic [7:0] rd1, rd2, op2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StIssue;
      StIssue: state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  if (cnt_q == 4'd0) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == StIdle);
    accept      = instr_valid & instr_ready;
    cfg_wr      = cfg_we & instr_ready;
    load_ops    = (state_q == StRead);
    // Opcode 0 is a NOP: no register or flag update.
    wb_we       = (state_q == StWb) & (instr_q[4:0] != OpNop);
  end

`ifdef ALU_ISSUE_IMMEDIATE_EN
  assign op2 = instr_q[ImmBit] ? addr_q : rd2;
`else
  assign op2 = rd2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      addr_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StWb);
      if (accept) begin
        instr_q <= instruct;
        addr_q  <= address;
      end
      if (load_ops) begin
        data1_q <= rd1;
        data2_q <= op2;
        cnt_q   <= WaitInit;
      end else if (state_q == StExec && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (wb_we) begin
        zero_q <= (alu_ans == 8'd0);
        neg_q  <= alu_ans[7];
      end
    end
  end

  regfile_8x8 u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .wb_we    (wb_we),
    .wb_addr  ({1'b0, alu_dr}),
    .wb_data  (alu_ans),
    .raddr1   (alu_wr1),
    .raddr2   (alu_wr2),
    .dbg_sel  (dbg_sel),
    .rdata1   (rd1),
    .rdata2   (rd2),
    .dbg_data (dbg_data)
  );

  assign alu_instruct = instr_q;
  assign alu_address  = addr_q;
  assign alu_data1    = data1_q;
  assign alu_data2    = data2_q;
  assign done         = done_q;
  assign zero_flag    = zero_q;
  assign neg_flag     = neg_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU stand-in.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int AluWait = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instruct = '0, address = '0;
  logic [7:0] alu_instruct, alu_address, alu_data1, alu_data2, alu_ans;
  logic [2:0] alu_wr1, alu_wr2;
  logic [1:0] alu_dr;
  logic       done, zero_flag, neg_flag;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [2:0] dbg_sel = '0;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_WAIT(AluWait)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruct     (instruct),
    .address      (address),
    .alu_instruct (alu_instruct),
    .alu_address  (alu_address),
    .alu_wr1      (alu_wr1),
    .alu_wr2      (alu_wr2),
    .alu_dr       (alu_dr),
    .alu_data1    (alu_data1),
    .alu_data2    (alu_data2),
    .alu_ans      (alu_ans),
    .done         (done),
    .zero_flag    (zero_flag),
    .neg_flag     (neg_flag),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // ALU stand-in: field decode plus add/sub variants.
  always_comb begin
    alu_wr1 = alu_address[7:5];
    alu_wr2 = alu_address[4:2];
    alu_dr  = alu_address[1:0];
    case (alu_instruct[4:0])
      5'd1, 5'd17: alu_ans = alu_data1 + alu_data2;
      5'd2, 5'd18: alu_ans = alu_data1 - alu_data2;
      default:     alu_ans = 8'h00;
    endcase
  end

  typedef struct {
    string      name;
    logic [7:0] ins;
    logic [7:0] adr;
    logic       pw;
    logic [2:0] pa;
    logic [7:0] pd;
    logic [2:0] dst;
    logic [7:0] val;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_chk(input string name, input logic [2:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    check(name, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Issue one instruction (optional same-cycle preload); lat = edges from accept to done.
  task automatic run_instr(input string name, input logic [7:0] ins, input logic [7:0] adr,
                           input logic pw, input logic [2:0] pa, input logic [7:0] pd,
                           output int lat);
    check({name, "_ready"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instruct = ins; address = adr;
    cfg_we = pw; cfg_addr = pa; cfg_data = pd;
    tick();
    instr_valid = 1'b0; cfg_we = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int accepts;
    int dones;
    logic acc;
    logic [7:0] imm_exp;

    vecs[0] = '{"add_r1_r2", 8'h01, 8'h28, 1'b1, 3'd2, 8'h03, 3'd0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{"sub_self",  8'h02, 8'h49, 1'b0, 3'd0, 8'h00, 3'd1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"add_wrap",  8'h01, 8'h6E, 1'b1, 3'd3, 8'h80, 3'd2, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{"src_eq_dst", 8'h01, 8'h63, 1'b0, 3'd0, 8'h00, 3'd3, 8'h88, 1'b0, 1'b1};
    vecs[4] = '{"nop",       8'h00, 8'h63, 1'b0, 3'd0, 8'h00, 3'd3, 8'h88, 1'b0, 1'b1};
    vecs[5] = '{"usub",      8'h12, 8'h0D, 1'b0, 3'd0, 8'h00, 3'd1, 8'h80, 1'b0, 1'b1};

    // Reset state
    tick();
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zero", {31'd0, zero_flag}, 32'd0);
    check("rst_neg", {31'd0, neg_flag}, 32'd0);
    check("rst_instr", {24'd0, alu_instruct}, 32'd0);
    check("rst_data1", {24'd0, alu_data1}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 8; i++) reg_chk($sformatf("rst_r%0d", i), 3'(i), 8'h00);

    preload(3'd1, 8'h05);

    for (int v = 0; v < 6; v++) begin
      run_instr(vecs[v].name, vecs[v].ins, vecs[v].adr, vecs[v].pw, vecs[v].pa, vecs[v].pd, lat);
      check({vecs[v].name, "_latency"}, lat, 3 + AluWait);
      tick();
      check({vecs[v].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      reg_chk({vecs[v].name, "_result"}, vecs[v].dst, vecs[v].val);
      check({vecs[v].name, "_zero"}, {31'd0, zero_flag}, {31'd0, vecs[v].z});
      check({vecs[v].name, "_neg"}, {31'd0, neg_flag}, {31'd0, vecs[v].n});
    end
    reg_chk("after_table_r0", 3'd0, 8'h08);
    reg_chk("after_table_r2", 3'd2, 8'h00);

    // Immediate operand (r1 preloaded in the accept cycle)
`ifdef ALU_ISSUE_IMMEDIATE_EN
    imm_exp = 8'h2C;
`else
    imm_exp = 8'h0A;
`endif
    run_instr("imm", 8'h41, 8'h27, 1'b1, 3'd1, 8'h05, lat);
    check("imm_latency", lat, 3 + AluWait);
    tick();
    reg_chk("imm_r3", 3'd3, imm_exp);

    // Held valid for 10 cycles with cfg_we driven while busy
    preload(3'd4, 8'h11);
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      instr_valid = 1'b1; instruct = 8'h01; address = 8'h28;
      cfg_we = ~instr_ready; cfg_addr = 3'd4; cfg_data = 8'hEE;
      acc = instr_valid & instr_ready;
      tick();
      if (acc) accepts++;
    end
    instr_valid = 1'b0; cfg_we = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
    check("hold_done_seen", {31'd0, done}, 32'd1);
    check("hold_accepts", accepts, 2);
    tick();
    reg_chk("hold_r4", 3'd4, 8'h11);
    reg_chk("hold_r0", 3'd0, 8'h05);

    // Reset during EXEC
    instr_valid = 1'b1; instruct = 8'h01; address = 8'h28;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_zero", {31'd0, zero_flag}, 32'd0);
    check("midrst_addr", {24'd0, alu_address}, 32'd0);
    check("midrst_data2", {24'd0, alu_data2}, 32'd0);
    for (int i = 0; i < 8; i++) reg_chk($sformatf("midrst_r%0d", i), 3'(i), 8'h00);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_ready_after", {31'd0, instr_ready}, 32'd1);
    reg_chk("midrst_r0_after", 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
